// File: rtl/second_game_pkg.sv
// rtl/second_game_pkg.sv - shared types and BCD helper for the second-game controller
package second_game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        PAUSED    = 3'd2,
        HIT       = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Ripple +1 across four BCD digits; caller guarantees the input is below 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        bcd_digit_t  d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = r[i*4 +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter_4.sv
// rtl/bcd_counter_4.sv - four-digit BCD counter with sync clear and saturation at 9999
module bcd_counter_4
    import second_game_pkg::*;
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [15:0] o_count,
    output logic        o_sat
);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != BCD_MAX)) begin
            r_count <= bcd_inc(r_count);
        end
    end

    assign o_count = r_count;
    assign o_sat   = (r_count == BCD_MAX);

endmodule

// File: rtl/second_game_controller.sv
// rtl/second_game_controller.sv - session FSM: start/pause, lives, hit freeze, BCD score, level
module second_game_controller
    import second_game_pkg::*;
#(
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 60,
    parameter int SCORE_DIV  = 6,
    parameter int LEVEL_STEP = 100
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        i_frame_tick,
    input  logic        i_button_start,
    input  logic        i_button_pause,
    input  logic        i_is_lose,
    output logic        o_is_pause,
    output logic        o_engine_rst_n,
    output logic [2:0]  o_state,
    output logic [2:0]  o_lives,
    output logic [15:0] o_score,
    output logic [15:0] o_high_score,
    output logic [2:0]  o_level,
    output logic        o_hit_blink
);

    localparam int HW = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
    localparam int DW = (SCORE_DIV  > 1) ? $clog2(SCORE_DIV)  : 1;
    localparam int LW = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;

    localparam logic [HW-1:0] HIT_LAST   = HW'(HIT_FRAMES - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCORE_DIV - 1);
    localparam logic [LW-1:0] LVL_LAST   = LW'(LEVEL_STEP - 1);
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

    state_t        r_state;
    logic [2:0]    r_lives;
    logic [15:0]   r_high;
    logic [2:0]    r_level;
    logic          r_is_pause;
    logic          r_engine_rst_n;
    logic          r_hit_blink;
    logic          r_start_q;
    logic          r_pause_q;
    logic          r_lose_q;
    logic [DW-1:0] r_div_cnt;
    logic [LW-1:0] r_lvl_cnt;
    logic [HW-1:0] r_hit_cnt;
    logic [3:0]    r_frame_cnt;

    logic          w_start_press;
    logic          w_pause_press;
    logic          w_lose_edge;
    logic          w_new_game;
    logic          w_score_tick;
    logic          w_score_inc;
    logic          w_score_sat;
    logic [15:0]   w_score;
    logic [3:0]    w_frame_nxt;

    assign w_start_press = i_button_start & ~r_start_q;
    assign w_pause_press = i_button_pause & ~r_pause_q;
    assign w_lose_edge   = i_is_lose & ~r_lose_q;
    assign w_new_game    = w_start_press & ((r_state == IDLE) | (r_state == GAME_OVER));
    assign w_score_tick  = (r_state == PLAY) & i_frame_tick & (r_div_cnt == DIV_LAST);
    assign w_score_inc   = w_score_tick & ~w_score_sat;
    assign w_frame_nxt   = r_frame_cnt + {3'b000, i_frame_tick};

    bcd_counter_4 u_score (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_clr   (w_new_game),
        .i_inc   (w_score_tick),
        .o_count (w_score),
        .o_sat   (w_score_sat)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state        <= IDLE;
            r_lives        <= LIVES_INIT;
            r_high         <= '0;
            r_level        <= '0;
            r_is_pause     <= 1'b1;
            r_engine_rst_n <= 1'b1;
            r_hit_blink    <= 1'b0;
            r_start_q      <= 1'b0;
            r_pause_q      <= 1'b0;
            r_lose_q       <= 1'b0;
            r_div_cnt      <= '0;
            r_lvl_cnt      <= '0;
            r_hit_cnt      <= '0;
            r_frame_cnt    <= '0;
        end else begin
            r_start_q      <= i_button_start;
            r_pause_q      <= i_button_pause;
            r_lose_q       <= i_is_lose;
            r_frame_cnt    <= w_frame_nxt;
            r_engine_rst_n <= 1'b1;
            r_hit_blink    <= 1'b0;

            // Level follows real score increments only, so a saturated score stops levelling.
            if (w_score_inc) begin
                if (r_lvl_cnt == LVL_LAST) begin
                    r_lvl_cnt <= '0;
                    if (r_level != 3'd7) begin
                        r_level <= r_level + 3'd1;
                    end
                end else begin
                    r_lvl_cnt <= r_lvl_cnt + LW'(1);
                end
            end

            case (r_state)
                IDLE, GAME_OVER: begin
                    if (w_start_press) begin
                        r_state        <= PLAY;
                        r_is_pause     <= 1'b0;
                        r_engine_rst_n <= 1'b0;
                        r_lives        <= LIVES_INIT;
                        r_level        <= '0;
                        r_lvl_cnt      <= '0;
                        r_div_cnt      <= '0;
                    end
                end
                PLAY: begin
                    if (i_frame_tick) begin
                        r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1);
                    end
                    // A loss outranks a pause press arriving in the same cycle.
                    if (w_lose_edge) begin
                        r_state     <= HIT;
                        r_is_pause  <= 1'b1;
                        r_hit_cnt   <= '0;
                        r_hit_blink <= w_frame_nxt[3];
                        if (r_lives != 3'd0) begin
                            r_lives <= r_lives - 3'd1;
                        end
                    end else if (w_pause_press) begin
                        r_state    <= PAUSED;
                        r_is_pause <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (w_pause_press) begin
                        r_state    <= PLAY;
                        r_is_pause <= 1'b0;
                    end
                end
                HIT: begin
                    r_hit_blink <= w_frame_nxt[3];
                    if (i_frame_tick) begin
                        if (r_hit_cnt == HIT_LAST) begin
                            r_hit_blink <= 1'b0;
                            if (r_lives != 3'd0) begin
                                r_state    <= PLAY;
                                r_is_pause <= 1'b0;
                            end else begin
                                r_state <= GAME_OVER;
                                // Valid BCD orders the same as binary, so a plain compare suffices.
                                if (w_score > r_high) begin
                                    r_high <= w_score;
                                end
                            end
                        end else begin
                            r_hit_cnt <= r_hit_cnt + HW'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_is_pause <= 1'b1;
                end
            endcase
        end
    end

    assign o_is_pause     = r_is_pause;
    assign o_engine_rst_n = r_engine_rst_n;
    assign o_state        = r_state;
    assign o_lives        = r_lives;
    assign o_score        = w_score;
    assign o_high_score   = r_high;
    assign o_level        = r_level;
    assign o_hit_blink    = r_hit_blink;

endmodule

// File: tb/tb_second_game_controller.sv
// tb/tb_second_game_controller.sv - scoreboard bench for second_game_controller
module tb_second_game_controller;
    import second_game_pkg::*;

    localparam int LIVES      = 3;
    localparam int HIT_FRAMES = 60;
    localparam int SCORE_DIV  = 6;
    localparam int LEVEL_STEP = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n = 1'b0, tick = 1'b0, b_start = 1'b0, b_pause = 1'b0, lose = 1'b0;
    logic        o_is_pause, o_engine_rst_n, o_hit_blink;
    logic [2:0]  o_state, o_lives, o_level;
    logic [15:0] o_score, o_high_score;

    logic        s_rst_n = 1'b0, s_tick = 1'b0, s_start = 1'b0;
    logic        s_is_pause, s_engine_rst_n, s_hit_blink;
    logic [2:0]  s_state, s_lives, s_level;
    logic [15:0] s_score, s_high_score;

    second_game_controller dut (
        .clk(clk), .arst_n(arst_n), .i_frame_tick(tick), .i_button_start(b_start),
        .i_button_pause(b_pause), .i_is_lose(lose), .o_is_pause(o_is_pause),
        .o_engine_rst_n(o_engine_rst_n), .o_state(o_state), .o_lives(o_lives),
        .o_score(o_score), .o_high_score(o_high_score), .o_level(o_level),
        .o_hit_blink(o_hit_blink)
    );

    second_game_controller #(.SCORE_DIV(1)) dut_sat (
        .clk(clk), .arst_n(s_rst_n), .i_frame_tick(s_tick), .i_button_start(s_start),
        .i_button_pause(1'b0), .i_is_lose(1'b0), .o_is_pause(s_is_pause),
        .o_engine_rst_n(s_engine_rst_n), .o_state(s_state), .o_lives(s_lives),
        .o_score(s_score), .o_high_score(s_high_score), .o_level(s_level),
        .o_hit_blink(s_hit_blink)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic        pause;
        logic        rst_n;
        logic [2:0]  lives;
        logic [15:0] score;
        logic [15:0] high;
        logic [2:0]  level;
        logic        blink;
    } obs_t;

    typedef struct {
        int   due;
        obs_t exp;
    } entry_t;

    entry_t sb_q[$];
    int     cyc = 0;
    int     n_tests = 0;
    int     n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain game rules with integer score and tick counts.
    state_t m_state;
    int     m_lives, m_play_ticks, m_high, m_frames, m_hit_ticks;
    bit     m_prev_s, m_prev_p, m_prev_l, m_rst_pulse;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic int m_score();
        int s;
        s = m_play_ticks / SCORE_DIV;
        return (s > 9999) ? 9999 : s;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        int   lv;
        lv      = m_score() / LEVEL_STEP;
        o.st    = m_state;
        o.pause = (m_state != PLAY);
        o.rst_n = !m_rst_pulse;
        o.lives = 3'(m_lives);
        o.score = to_bcd(m_score());
        o.high  = to_bcd(m_high);
        o.level = 3'((lv > 7) ? 7 : lv);
        o.blink = (m_state == HIT) && ((m_frames % 16) >= 8);
        return o;
    endfunction

    task automatic model_step(input bit r, input bit t, input bit s, input bit p, input bit l);
        bit sp, pp, le;
        if (!r) begin
            m_state = IDLE; m_lives = LIVES; m_play_ticks = 0; m_high = 0;
            m_frames = 0; m_hit_ticks = 0; m_rst_pulse = 0;
            m_prev_s = 0; m_prev_p = 0; m_prev_l = 0;
            return;
        end
        sp = s && !m_prev_s;
        pp = p && !m_prev_p;
        le = l && !m_prev_l;
        m_rst_pulse = 0;
        case (m_state)
            IDLE, GAME_OVER: if (sp) begin
                m_state = PLAY; m_lives = LIVES; m_play_ticks = 0; m_rst_pulse = 1;
            end
            PLAY: begin
                if (t) m_play_ticks++;
                if (le) begin
                    m_state = HIT; m_hit_ticks = 0;
                    if (m_lives > 0) m_lives--;
                end else if (pp) begin
                    m_state = PAUSED;
                end
            end
            PAUSED: if (pp) m_state = PLAY;
            HIT: if (t) begin
                m_hit_ticks++;
                if (m_hit_ticks == HIT_FRAMES) begin
                    if (m_lives != 0) begin
                        m_state = PLAY;
                    end else begin
                        m_state = GAME_OVER;
                        if (m_score() > m_high) m_high = m_score();
                    end
                end
            end
            default: m_state = IDLE;
        endcase
        if (t) m_frames++;
        m_prev_s = s; m_prev_p = p; m_prev_l = l;
    endtask

    task automatic drive(input bit r, input bit t, input bit s, input bit p, input bit l);
        entry_t e;
        @(posedge clk);
        #1;
        arst_n = r; tick = t; b_start = s; b_pause = p; lose = l;
        model_step(r, t, s, p, l);
        e.due = cyc + 1;
        e.exp = model_obs();
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 1, 0, 0, 0);
            drive(1, 0, 0, 0, 0);
        end
    endtask

    task automatic press_start();
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic press_pause();
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: every registered output set is compared once its expected entry falls due.
    initial begin
        entry_t e;
        obs_t   a;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                a = '{o_state, o_is_pause, o_engine_rst_n, o_lives, o_score,
                      o_high_score, o_level, o_hit_blink};
                n_tests++;
                if (a !== e.exp) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d got st=%0d pz=%b rst=%b lv=%0d sc=%h hi=%h lvl=%0d bl=%b exp st=%0d pz=%b rst=%b lv=%0d sc=%h hi=%h lvl=%0d bl=%b",
                             cyc, a.st, a.pause, a.rst_n, a.lives, a.score, a.high, a.level, a.blink,
                             e.exp.st, e.exp.pause, e.exp.rst_n, e.exp.lives, e.exp.score,
                             e.exp.high, e.exp.level, e.exp.blink);
                end
            end
        end
    end

    initial begin
        bit rs, rp, rl;
        int wait_cyc;

        drive(0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 0);
        idle(3);

        // New game, 60 scoring ticks, then a pause window.
        press_start();
        ticks(60);
        press_pause();
        ticks(30);
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        press_pause();
        ticks(5);

        // Wide loss pulse costs one life, freeze lasts HIT_FRAMES ticks.
        for (int i = 0; i < 5; i++) drive(1, i % 2, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        ticks(62);

        // Loss and pause press in the same cycle.
        drive(1, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0);
        ticks(61);

        // Last life, then game over.
        drive(1, 1, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        ticks(62);
        idle(3);

        // Short second game, lower score keeps the old high score.
        press_start();
        ticks(10);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 1);
            drive(1, 0, 0, 0, 0);
            ticks(61);
        end
        idle(2);

        // Randomized mixture including occasional mid-game resets.
        rs = 0; rp = 0; rl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(24) == 0) rs = ~rs;
            if ($urandom_range(14) == 0) rp = ~rp;
            if ($urandom_range(19) == 0) rl = ~rl;
            drive(($urandom_range(599) != 0), ($urandom_range(2) == 0), rs, rp, rl);
        end

        // Reset landing in the middle of a hit freeze.
        drive(0, 0, 0, 0, 0);
        idle(2);
        press_start();
        ticks(4);
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        ticks(20);
        drive(0, 1, 1, 1, 1);
        drive(1, 0, 0, 0, 0);
        idle(3);

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

        // Score saturation on a SCORE_DIV=1 instance.
        @(posedge clk); #1 s_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 s_rst_n = 1'b1; s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0; s_tick = 1'b1;
        repeat (9998) @(posedge clk);
        #1 s_tick = 1'b0;
        @(negedge clk);
        check("sat_score_9998", 32'(s_score), 32'h9998);
        check("sat_level_7", 32'(s_level), 32'd7);
        check("sat_state_play", 32'(s_state), 32'(PLAY));
        @(posedge clk); #1 s_tick = 1'b1;
        repeat (12) @(posedge clk);
        #1 s_tick = 1'b0;
        @(negedge clk);
        check("sat_score_9999", 32'(s_score), 32'h9999);
        check("sat_level_held", 32'(s_level), 32'd7);
        check("sat_unpaused", 32'(s_is_pause), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
